// File: rtl/rev_counter_pkg.sv
// Shared constants and terminal-count helper for the rev_counter family.
// Saturating mode is selected by defining REVCNT_SAT_EN (see rev_counter_mod).
package rev_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int REVCNT_WIDTH = 16;

    // Operands are zero-extended to 32 bits so one function serves every width.
    function automatic logic term_hit(input logic [31:0] c,
                                      input logic [31:0] l,
                                      input logic        s);
        return (s & (c >= l)) | (~s & (c == 32'd0));
    endfunction

endpackage

// File: rtl/rev_counter_tc.sv
// Combinational terminal-count and cascade carry detector for an up/down counter.
module rev_counter_tc
    import rev_counter_pkg::*;
#(
    parameter int WIDTH = REVCNT_WIDTH
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] lim,
    input  logic             s,
    input  logic             en,
    input  logic             cin,
    output logic             rc,
    output logic             co
);

    always_comb begin
        rc = term_hit(32'(cnt), 32'(lim), s);
        co = rc & en & cin;
    end

endmodule

// File: rtl/rev_counter_mod.sv
// Cascadable up/down modulo counter with load, programmable limit and terminal pulse.
// Define REVCNT_SAT_EN to make the count saturate at the terminal instead of wrapping.
module rev_counter_mod
    import rev_counter_pkg::*;
#(
    parameter int               WIDTH    = REVCNT_WIDTH,
    parameter logic [WIDTH-1:0] LIM_INIT = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cin,
    input  logic             s,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             lim_we,
    input  logic [WIDTH-1:0] lim_d,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] lim,
    output logic             Rc,
    output logic             co,
    output logic             tc_q
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] wrap_val;

    rev_counter_tc #(.WIDTH(WIDTH)) u_tc (
        .cnt (cnt),
        .lim (lim),
        .s   (s),
        .en  (en),
        .cin (cin),
        .rc  (Rc),
        .co  (co)
    );

    // Value taken when a counted edge lands on the terminal count.
    always_comb begin
`ifdef REVCNT_SAT_EN
        wrap_val = (s == DIR_UP) ? cnt : ZERO;
`else
        wrap_val = (s == DIR_UP) ? ZERO : lim;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= ZERO;
            lim  <= LIM_INIT;
            tc_q <= 1'b0;
        end else begin
            // The count below still sees the old lim; a new limit applies next cycle.
            if (lim_we) begin
                lim <= lim_d;
            end
            tc_q <= co & ~ld;
            if (ld) begin
                cnt <= d;
            end else if (en & cin) begin
                if (Rc) begin
                    cnt <= wrap_val;
                end else if (s == DIR_UP) begin
                    cnt <= cnt + ONE;
                end else begin
                    cnt <= cnt - ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_rev_counter_mod.sv
// Directed self-checking bench for rev_counter_mod (WIDTH=4, LIM_INIT=15), incl. a two-digit cascade.
module tb_rev_counter_mod;

    localparam int W = 4;
`ifdef REVCNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, en, cin, s, ld, lim_we;
    logic [W-1:0] d, lim_d;
    logic [W-1:0] cnt, lim;
    logic         rc, co, tc_q;

    logic         hi_en, hi_s, hi_ld, hi_lim_we;
    logic [W-1:0] hi_d, hi_lim_d;
    logic [W-1:0] hi_cnt, hi_lim;
    logic         hi_rc, hi_co, hi_tc_q;

    logic [W-1:0] exp_q[$];
    int           n_pass  = 0;
    int           n_total = 0;

    always #5 clk = ~clk;

    rev_counter_mod #(.WIDTH(W), .LIM_INIT(4'd15)) dut (
        .clk(clk), .rst(rst), .en(en), .cin(cin), .s(s), .ld(ld), .d(d),
        .lim_we(lim_we), .lim_d(lim_d), .cnt(cnt), .lim(lim),
        .Rc(rc), .co(co), .tc_q(tc_q)
    );

    rev_counter_mod #(.WIDTH(W), .LIM_INIT(4'd15)) dut_hi (
        .clk(clk), .rst(rst), .en(hi_en), .cin(co), .s(hi_s), .ld(hi_ld), .d(hi_d),
        .lim_we(hi_lim_we), .lim_d(hi_lim_d), .cnt(hi_cnt), .lim(hi_lim),
        .Rc(hi_rc), .co(hi_co), .tc_q(hi_tc_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lims(input logic [W-1:0] v);
        en = 1'b0; hi_en = 1'b0;
        lim_we = 1'b1; lim_d = v;
        hi_lim_we = 1'b1; hi_lim_d = v;
        tick();
        lim_we = 1'b0; hi_lim_we = 1'b0;
    endtask

    task automatic load(input logic [W-1:0] v);
        en = 1'b0;
        ld = 1'b1; d = v;
        tick();
        ld = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b1; cin = 1'b1; s = 1'b1; ld = 1'b0; d = '0;
        lim_we = 1'b0; lim_d = '0;
        hi_en = 1'b0; hi_s = 1'b1; hi_ld = 1'b0; hi_d = '0;
        hi_lim_we = 1'b0; hi_lim_d = '0;

        // Reset
        tick();
        check("rst_cnt", 32'(cnt), 0);
        check("rst_lim", 32'(lim), 15);
        check("rst_tc_q", 32'(tc_q), 0);
        check("rst_rc_up", 32'(rc), 0);
        rst = 1'b0; en = 1'b0; s = 1'b0;
        #1;
        check("rst_rc_down", 32'(rc), 1);
        check("rst_co_noen", 32'(co), 0);

        // Modulo-10 up count
        set_lims(4'd9);
        check("lim_write", 32'(lim), 9);
        check("hi_lim_write", 32'(hi_lim), 9);
        for (int i = 1; i <= 9; i++) exp_q.push_back(W'(i));
        if (SAT) begin
            exp_q.push_back(4'd9); exp_q.push_back(4'd9); exp_q.push_back(4'd9);
        end else begin
            exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd2);
        end
        en = 1'b1; cin = 1'b1; s = 1'b1;
        #1;
        for (int i = 0; i < 12; i++) begin
            check("mod_up_co", 32'(co), (i == 9 || (SAT && i > 9)) ? 1 : 0);
            tick();
            check("mod_up_cnt", 32'(cnt), 32'(exp_q.pop_front()));
            check("mod_up_tc_q", 32'(tc_q), (i == 9 || (SAT && i > 9)) ? 1 : 0);
        end
        check("hi_idle", 32'(hi_cnt), 0);

        // Out-of-range load then down count through zero
        load(4'd12);
        check("load_oor", 32'(cnt), 12);
        check("load_tc_q", 32'(tc_q), 0);
        s = 1'b1;
        #1;
        check("rc_up_above_lim", 32'(rc), 1);
        for (int v = 11; v >= 0; v--) exp_q.push_back(W'(v));
        exp_q.push_back(SAT ? 4'd0 : 4'd9);
        s = 1'b0; en = 1'b1;
        #1;
        for (int i = 0; i < 13; i++) begin
            check("down_co", 32'(co), (i == 12) ? 1 : 0);
            tick();
            check("down_cnt", 32'(cnt), 32'(exp_q.pop_front()));
            check("down_tc_q", 32'(tc_q), (i == 12) ? 1 : 0);
        end

        // Load beats a terminal count; reset beats load and limit write
        load(4'd9);
        s = 1'b1; en = 1'b1; cin = 1'b1; ld = 1'b1; d = 4'd5;
        #1;
        check("prio_co", 32'(co), 1);
        tick();
        check("prio_ld_cnt", 32'(cnt), 5);
        check("prio_ld_tc_q", 32'(tc_q), 0);
        rst = 1'b1; ld = 1'b1; d = 4'd7; lim_we = 1'b1; lim_d = 4'd3;
        tick();
        check("prio_rst_cnt", 32'(cnt), 0);
        check("prio_rst_lim", 32'(lim), 15);
        rst = 1'b0; ld = 1'b0; lim_we = 1'b0;

        // Hold on cin=0
        load(4'd6);
        en = 1'b1; cin = 1'b0; s = 1'b1;
        tick();
        check("hold_cnt", 32'(cnt), 6);
        check("hold_co", 32'(co), 0);
        check("hold_tc_q", 32'(tc_q), 0);
        cin = 1'b1;

        // Limit write applies one cycle late
        load(4'd3);
        en = 1'b1; s = 1'b1; lim_we = 1'b1; lim_d = 4'd3;
        tick();
        lim_we = 1'b0;
        check("limw_old_lim_cnt", 32'(cnt), 4);
        check("limw_new_lim", 32'(lim), 3);
        check("limw_rc", 32'(rc), 1);
        tick();
        check("limw_wrap_cnt", 32'(cnt), SAT ? 4 : 0);
        check("limw_tc_q", 32'(tc_q), 1);

        // Degenerate limit of zero
        set_lims(4'd0);
        load(4'd0);
        en = 1'b1; s = 1'b1;
        tick();
        check("lim0_up_cnt", 32'(cnt), 0);
        check("lim0_up_rc", 32'(rc), 1);
        check("lim0_up_tc_q", 32'(tc_q), 1);
        s = 1'b0;
        tick();
        check("lim0_down_cnt", 32'(cnt), 0);

`ifndef REVCNT_SAT_EN
        // Two-digit decimal cascade
        set_lims(4'd9);
        hi_ld = 1'b1; hi_d = 4'd0;
        load(4'd0);
        hi_ld = 1'b0;
        en = 1'b1; cin = 1'b1; s = 1'b1; hi_en = 1'b1; hi_s = 1'b1;
        for (int i = 0; i < 25; i++) tick();
        check("casc_up_lo", 32'(cnt), 5);
        check("casc_up_hi", 32'(hi_cnt), 2);
        hi_en = 1'b0; hi_ld = 1'b1; hi_d = 4'd2;
        load(4'd0);
        hi_ld = 1'b0;
        en = 1'b1; s = 1'b0; hi_en = 1'b1; hi_s = 1'b0;
        for (int i = 0; i < 21; i++) tick();
        check("casc_down_lo", 32'(cnt), 9);
        check("casc_down_hi", 32'(hi_cnt), 9);
        hi_en = 1'b0;
`endif

        // Behaviour at the terminal over repeated counted edges
        set_lims(4'd9);
        load(4'd9);
        en = 1'b1; s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("term_up_cnt", 32'(cnt), SAT ? 9 : i);
            check("term_up_tc_q", 32'(tc_q), (SAT || i == 0) ? 1 : 0);
        end
        load(4'd0);
        en = 1'b1; s = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("term_down_cnt", 32'(cnt), SAT ? 0 : 9 - i);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
